// File: rtl/hack_soc_pkg.sv
// Shared constants and types for the Hack SoC ROM loader: register map,
// CTRL/STATUS bit positions and the loader handshake state encoding.
package hack_soc_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_DATA   = 4'h8;
  localparam logic [3:0] REG_SENT   = 4'hC;

  localparam int CTRL_LOAD   = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_SCK_HI = 2'd2,
    ST_SCK_LO = 2'd3
  } loader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    // Flush drops everything queued, including a same-cycle push.
    if (flush_i) rd_ptr_d = wr_ptr_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/wb_rom_loader.sv
// Wishbone-mapped ROM loader: firmware queues words in a FIFO and a
// handshake engine drives the SoC rom_loader sck/load/data/ack lines.
module wb_rom_loader
  import hack_soc_pkg::*;
#(
  parameter int          DATA_WIDTH   = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          SETUP_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  loader_load,
  output logic                  loader_sck,
  output logic [DATA_WIDTH-1:0] loader_data,
  input  logic                  loader_ack,
  output logic                  irq,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

  loader_state_t         state_q, state_d;
  logic [SW-1:0]         setup_cnt_q, setup_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  load_q, load_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic [31:0]           sent_q, sent_d;

  logic                  req, wr_en, wr_ctrl, wr_status, wr_data, wr_sent;
  logic [3:0]            reg_off;
  logic                  flush, push, pop, sent_inc, busy, ovf_set;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  // Ack is one registered cycle per request, forced low for a cycle after.
  assign req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign ack_d     = req & ~ack_q;
  assign reg_off   = {wbs_adr_i[3:2], 2'b00};
  assign wr_en     = ack_q & req & wbs_we_i;
  assign wr_ctrl   = wr_en & (reg_off == REG_CTRL);
  assign wr_status = wr_en & (reg_off == REG_STATUS);
  assign wr_data   = wr_en & (reg_off == REG_DATA);
  assign wr_sent   = wr_en & (reg_off == REG_SENT);

  assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
  // A push into a full FIFO is accepted when the engine pops in the same cycle.
  assign push    = wr_data & (~fifo_full | pop);
  assign ovf_set = wr_data & fifo_full & ~pop;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wbs_dat_i[DATA_WIDTH-1:0]),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    pop         = 1'b0;
    sent_inc    = 1'b0;
    case (state_q)
      ST_IDLE: if (load_q && !fifo_empty) begin
        pop         = 1'b1;
        setup_cnt_d = '0;
        state_d     = ST_SETUP;
      end
      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) state_d = ST_SCK_HI;
        else setup_cnt_d = setup_cnt_q + SW'(1);
      end
      ST_SCK_HI: if (loader_ack) state_d = ST_SCK_LO;
      ST_SCK_LO: if (!loader_ack) begin
        state_d  = ST_IDLE;
        sent_inc = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_d   = load_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    sent_d   = sent_q;
    data_d   = pop ? fifo_head : data_q;
    if (wr_ctrl) begin
      load_d   = wbs_dat_i[CTRL_LOAD];
      irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
    end
    if (ovf_set) ovf_d = 1'b1;
    else if (wr_status && wbs_dat_i[STAT_OVERFLOW]) ovf_d = 1'b0;
    if (wr_sent) sent_d = '0;
    else if (sent_inc) sent_d = sent_q + 32'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      load_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      load_q      <= load_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      sent_q      <= sent_d;
    end
  end

  always_comb begin
    wbs_dat_o = '0;
    if (ack_q) begin
      case (reg_off)
        REG_CTRL: begin
          wbs_dat_o[CTRL_LOAD]   = load_q;
          wbs_dat_o[CTRL_IRQ_EN] = irq_en_q;
        end
        REG_STATUS: begin
          wbs_dat_o[STAT_EMPTY]    = fifo_empty;
          wbs_dat_o[STAT_FULL]     = fifo_full;
          wbs_dat_o[STAT_BUSY]     = busy;
          wbs_dat_o[STAT_OVERFLOW] = ovf_q;
          wbs_dat_o[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
        end
        REG_SENT: wbs_dat_o = sent_q;
        default:  wbs_dat_o = '0;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign wbs_ack_o   = ack_q;
  assign loader_load = load_q;
  assign loader_sck  = (state_q == ST_SCK_HI);
  assign loader_data = data_q;
  assign irq         = irq_en_q & fifo_empty & ~busy;
  assign dbg_state_o = state_q;

endmodule

// File: doc/wb_rom_loader.md
# wb_rom_loader

Wishbone-mapped ROM loader for the Hack SoC that replaces bit-banging of the loader lines from the logic analyser. Firmware pushes words into a FIFO over Wishbone. A handshake engine drains the FIFO and drives the hack_soc `rom_loader_sck` / `rom_loader_load` / `rom_loader_data` / `rom_loader_ack` interface. It sits in the Caravel user wrapper between the Wishbone slave port and the SoC loader inputs, generalised in word width, FIFO depth and handshake setup time.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of a loader word.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of 2 and ≥ 2.
- `SETUP_CYCLES`, default 2: cycles `loader_data` is held stable before `loader_sck` rises; must be ≥ 1.
- `BASE_ADDR`, default 32'h3000_0000: register window base; the low 4 bits are ignored.

Ports:
- `wb_clk_i`  in  1  clock. One clock; reset is synchronous and active-high.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte selects; ignored, every access is treated as a full word.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  Wishbone acknowledge.
- `wbs_dat_o`  out  32  Wishbone read data.
- `loader_load`  out  1  to SoC `rom_loader_load`.
- `loader_sck`  out  1  to SoC `rom_loader_sck`.
- `loader_data`  out  DATA_WIDTH  to SoC `rom_loader_data`.
- `loader_ack`  in  1  from SoC `rom_loader_ack`; same clock domain, sampled directly.
- `irq`  out  1  level "drained" interrupt.

## Operation
Registers (offsets from BASE_ADDR):
- 0x0 CTRL (R/W)
  - bit0 `load`: drives `loader_load` directly.
  - bit1 `flush`: write-1 self-clearing; reads 0.
  - bit2 `irq_en`.
- 0x4 STATUS (RO, except bit3)
  - bit0 `empty`, bit1 `full`, bit2 `busy` (FSM not IDLE).
  - bit3 `overflow`: sticky; write 1 to clear.
  - [15:8] FIFO `count`.
- 0x8 DATA (WO): a write pushes `wbs_dat_i[DATA_WIDTH-1:0]`. Reads return 0.
- 0xC SENT (R/W): 32-bit count of completed words; wraps at 2^32. Any write clears it.

FIFO rules:
- DATA write while `full`: word dropped, `overflow` set.
- Push and pop in the same cycle: count unchanged. This also holds when full, where the push is accepted.
- `flush`: empties queued entries only. A word already in the handshake completes.

FSM:
- IDLE → SETUP when `load` = 1 and FIFO not empty. On this transition the FIFO head pops into the `loader_data` register.
- SETUP: `loader_sck` = 0; hold for SETUP_CYCLES cycles, then → SCK_HI.
- SCK_HI: `loader_sck` = 1; stay until `loader_ack` = 1, then → SCK_LO.
- SCK_LO: `loader_sck` = 0; stay until `loader_ack` = 0, then → IDLE and SENT increments.
- `load` cleared mid-word: the current handshake completes; no further pops.
- There is no timeout; a stuck `loader_ack` holds `busy` = 1 until reset.
- `irq` = `irq_en` & `empty` & ~`busy`.

## Timing
Wishbone:
- Only addresses matching BASE_ADDR[31:4] are acknowledged. Other addresses get no ack.
- `wbs_ack_o` is registered: asserted the cycle after `stb`&`cyc`, held for one cycle, then low for at least one cycle.
- `wbs_dat_o` is valid while ack is high and 0 otherwise.
- Register writes take effect on the cycle ack is high.

Loader:
- `loader_data` changes only on the IDLE → SETUP transition.
- With `loader_ack` equal to `loader_sck` delayed by one cycle, each word takes SETUP_CYCLES + 5 cycles, IDLE to IDLE.

Reset:
- All outputs 0, FIFO empty, SENT 0, CTRL 0, `overflow` 0, FSM in IDLE.
- Reset mid-handshake aborts the word immediately.

## Structure
- Shared package `hack_soc_pkg`:
  - register offset constants.
  - CTRL/STATUS bit-index constants.
  - FSM state enum `loader_state_t`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): pointers carry an extra wrap bit; outputs full, empty and count.
- Top level: Wishbone decode, registers, FSM.

## Test plan
- **Basic transfer:** write CTRL=1, push 0x1234, 0xABCD; ack model follows sck with 1-cycle delay. Expect two sck pulses with `loader_data` 0x1234 then 0xABCD, SENT=2, words SETUP_CYCLES+5 cycles apart.
- **Overflow:** with `load`=0, push FIFO_DEPTH+1 words. Expect STATUS `full`=1, `overflow`=1, count=FIFO_DEPTH; last word absent once drained. Write STATUS bit3=1 → `overflow` 0.
- **Load drop / flush mid-word:** clear `load` or write `flush` during SCK_HI. Expect the current word to finish and SENT +1. With `load` cleared, remaining words stay queued. With `flush`, count=0.
- **Stuck ack:** hold `loader_ack`=0. Expect FSM to stay in SCK_HI with `busy`=1. Assert `wb_rst_i` for one cycle → all outputs 0 and FIFO empty on the next cycle.
- **IRQ and decode:** set `irq_en`=1 and drain 3 words. Expect `irq` to rise in the cycle after the final SCK_LO → IDLE transition. An access to BASE_ADDR+0x10 gets no `wbs_ack_o`.
